// File: rtl/osc_meas_scheduler_pkg.sv
// rtl/osc_meas_scheduler_pkg.sv - shared types and constants for the oscillator measurement scheduler
package osc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  localparam logic [1:0] MODE_ALT  = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_NAND = 2'b10;

  localparam logic SRC_INV  = 1'b0;
  localparam logic SRC_NAND = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Down-counter width able to hold N-1 for the longest phase; never below 1 bit.
  function automatic int timer_w(input int max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/osc_meas_scheduler_if.sv
// rtl/osc_meas_scheduler_if.sv - result buffer handshake towards the averaging/send path
interface osc_meas_scheduler_if #(
  parameter int CNT_W = 16
) ();

  logic [CNT_W-1:0] res_data;
  logic             res_src;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output res_data,
    output res_src,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_src,
    input  res_valid,
    output res_ready
  );

endinterface

// File: rtl/osc_meas_scheduler_sched_timer.sv
// rtl/osc_meas_scheduler_sched_timer.sv - loadable phase down-counter with zero flag
module sched_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/osc_meas_scheduler.sv
// rtl/osc_meas_scheduler.sv - sequences ring oscillators and edge counter through timed measurements
module osc_meas_scheduler
  import osc_sched_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1000,
  parameter int GAP_CYC    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      osc_count,
  output logic                  en_inv_osc,
  output logic                  en_nand_osc,
  output logic                  osc_sel,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  osc_meas_scheduler_if.master  res,
  output logic                  overrun,
  output logic                  busy
);

  localparam int TW = timer_w(max3(SETTLE_CYC, WINDOW_CYC, GAP_CYC));

  state_e           state_q, state_d;
  logic             src_q, src_d;
  logic             next_src_q, next_src_d;
  logic             alt_q, alt_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             rsrc_q, rsrc_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             sel_src, sel_alt;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]    tmr_val;
  logic             capture;
  logic             handshake;
  logic             osc_on;

  sched_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Source for a measurement starting now; only consumed on SETTLE entry.
  always_comb begin
    sel_src = next_src_q;
    sel_alt = 1'b1;
    case (mode)
      MODE_INV: begin
        sel_src = SRC_INV;
        sel_alt = 1'b0;
      end
      MODE_NAND: begin
        sel_src = SRC_NAND;
        sel_alt = 1'b0;
      end
      default: begin
        sel_src = next_src_q;
        sel_alt = 1'b1;
      end
    endcase
  end

  // Phase sequencing; run=0 in an oscillating phase aborts without a result.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    alt_d      = alt_q;
    next_src_d = next_src_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_SETTLE;
          src_d    = sel_src;
          alt_d    = sel_alt;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d  = ST_MEASURE;
          tmr_load = 1'b1;
          tmr_val  = TW'(WINDOW_CYC - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          capture  = 1'b1;
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYC - 1);
          if (alt_q) begin
            next_src_d = ~next_src_q;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (run) begin
            state_d  = ST_SETTLE;
            src_d    = sel_src;
            alt_d    = sel_alt;
            tmr_load = 1'b1;
            tmr_val  = TW'(SETTLE_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-entry result buffer; a capture into a full, unacknowledged buffer is dropped.
  always_comb begin
    handshake = valid_q & res.res_ready;
    data_d    = data_q;
    rsrc_d    = rsrc_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;
    if (capture) begin
      if (!valid_q || handshake) begin
        data_d  = osc_count;
        rsrc_d  = src_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_INV;
      next_src_q <= SRC_INV;
      alt_q      <= 1'b0;
      data_q     <= '0;
      rsrc_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      next_src_q <= next_src_d;
      alt_q      <= alt_d;
      data_q     <= data_d;
      rsrc_q     <= rsrc_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign osc_on      = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_CAPTURE);
  assign en_inv_osc  = osc_on && (src_q == SRC_INV);
  assign en_nand_osc = osc_on && (src_q == SRC_NAND);
  assign osc_sel     = osc_on && src_q;
  assign cnt_clr     = (state_q == ST_SETTLE);
  assign cnt_en      = (state_q == ST_MEASURE);
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = ovr_q;

  assign res.res_data  = data_q;
  assign res.res_src   = rsrc_q;
  assign res.res_valid = valid_q;

endmodule

// File: tb/tb_osc_meas_scheduler.sv
// tb/tb_osc_meas_scheduler.sv - scoreboard bench for osc_meas_scheduler
module tb_osc_meas_scheduler;

  localparam int CNT_W = 16;
  localparam int S     = 4;
  localparam int W     = 10;
  localparam int G     = 2;
  localparam int CAP   = S + W;
  localparam int P     = S + W + 1 + G;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             run       = 1'b0;
  logic [1:0]       mode      = 2'b00;
  logic [CNT_W-1:0] osc_count = '0;
  logic             ready     = 1'b1;
  logic             en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_en, overrun, busy;

  osc_meas_scheduler_if #(.CNT_W(CNT_W)) res_if ();
  assign res_if.res_ready = ready;

  osc_meas_scheduler #(
    .CNT_W(CNT_W), .SETTLE_CYC(S), .WINDOW_CYC(W), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .osc_count(osc_count),
    .en_inv_osc(en_inv_osc), .en_nand_osc(en_nand_osc), .osc_sel(osc_sel),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .res(res_if), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ovr_seen = 0;
  bit rand_cnt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: position k inside a measurement of period P, plus an expected-result queue.
  typedef struct { logic [CNT_W-1:0] data; logic src; } res_t;
  res_t exp_q[$];
  bit   m_active   = 1'b0;
  int   m_k        = 0;
  bit   m_src      = 1'b0;
  bit   m_next_src = 1'b0;
  bit   m_alt      = 1'b0;
  bit   m_ovr      = 1'b0;

  task automatic m_start();
    m_active = 1'b1;
    m_k      = 0;
    if (mode == 2'b01)      begin m_src = 1'b0; m_alt = 1'b0; end
    else if (mode == 2'b10) begin m_src = 1'b1; m_alt = 1'b0; end
    else                    begin m_src = m_next_src; m_alt = 1'b1; end
  endtask

  // Monitor + model: compare outputs, retire handshakes, then advance the model one cycle.
  always @(negedge clk) begin
    bit   on;
    bit   ovr_n;
    res_t r;
    if (!rst_n) begin
      m_active   = 1'b0;
      m_next_src = 1'b0;
      m_ovr      = 1'b0;
      exp_q.delete();
      chk("rst_en_inv", en_inv_osc, 0);
      chk("rst_en_nand", en_nand_osc, 0);
      chk("rst_valid", res_if.res_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      on = m_active && (m_k <= CAP);
      chk("en_inv", en_inv_osc, on && !m_src);
      chk("en_nand", en_nand_osc, on && m_src);
      chk("osc_sel", osc_sel, on && m_src);
      chk("cnt_clr", cnt_clr, m_active && (m_k < S));
      chk("cnt_en", cnt_en, m_active && (m_k >= S) && (m_k < CAP));
      chk("busy", busy, m_active);
      chk("overrun", overrun, m_ovr);
      chk("res_valid", res_if.res_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("res_data_hold", res_if.res_data, exp_q[0].data);
        chk("res_src_hold", res_if.res_src, exp_q[0].src);
      end
      if (overrun) ovr_seen++;
      if (res_if.res_valid && ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", exp_q.size(), 1);
        else begin
          r = exp_q.pop_front();
          chk("pop_data", res_if.res_data, r.data);
          chk("pop_src", res_if.res_src, r.src);
        end
      end
      ovr_n = 1'b0;
      if (!m_active) begin
        if (run) m_start();
      end else if (m_k <= CAP) begin
        if (!run) m_active = 1'b0;
        else begin
          if (m_k == CAP) begin
            r.data = osc_count;
            r.src  = m_src;
            if (exp_q.size() == 0) exp_q.push_back(r);
            else ovr_n = 1'b1;
            if (m_alt) m_next_src = !m_src;
          end
          m_k++;
        end
      end else if (m_k == P - 1) begin
        if (run) m_start();
        else m_active = 1'b0;
      end else begin
        m_k++;
      end
      m_ovr = ovr_n;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_cnt) osc_count = CNT_W'($urandom);
    end
  endtask

  initial begin
    bit exp_src;
    step(3);
    rst_n = 1'b1;

    // Alternating mode timing from a fresh reset.
    osc_count = 16'h1234; mode = 2'b00; run = 1'b1; ready = 1'b1;
    step(1);
    chk("t1_settle_inv", en_inv_osc, 1);
    chk("t1_settle_clr", cnt_clr, 1);
    step(15);
    chk("t1_valid", res_if.res_valid, 1);
    chk("t1_data", res_if.res_data, 16'h1234);
    chk("t1_src", res_if.res_src, 0);
    step(2);
    chk("t1_nand", en_nand_osc, 1);
    chk("t1_sel", osc_sel, 1);
    step(40);

    // NAND-only mode for several periods.
    mode = 2'b10;
    step(60);
    run = 1'b0;
    step(25);

    // Two captures with the consumer stalled.
    ready = 1'b0; ovr_seen = 0; mode = 2'b01; osc_count = 16'h0100; run = 1'b1;
    step(16);
    osc_count = 16'h0200;
    step(17);
    run = 1'b0;
    step(10);
    chk("ovr_data", res_if.res_data, 16'h0100);
    chk("ovr_pulses", ovr_seen, 1);
    ready = 1'b1;
    step(1);
    step(1);
    chk("drain_valid", res_if.res_valid, 0);

    // Capture coinciding with a handshake.
    ready = 1'b0; ovr_seen = 0; osc_count = 16'h0A0A; run = 1'b1;
    step(16);
    osc_count = 16'h0B0B;
    step(16);
    ready = 1'b1;
    step(1);
    chk("coinc_valid", res_if.res_valid, 1);
    chk("coinc_data", res_if.res_data, 16'h0B0B);
    chk("coinc_ovr", ovr_seen, 0);
    run = 1'b0;
    step(10);

    // Abort in the third MEASURE cycle; next run repeats the same source.
    mode = 2'b00; exp_src = m_next_src; run = 1'b1;
    step(7);
    chk("abort_in_measure", cnt_en, 1);
    run = 1'b0;
    step(1);
    chk("abort_idle", busy, 0);
    chk("abort_cnt_en", cnt_en, 0);
    step(2);
    run = 1'b1;
    step(1);
    chk("abort_same_src", en_nand_osc, exp_src);
    step(20);

    // Randomized run/mode/ready/count traffic.
    rand_cnt = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (run && $urandom_range(0, 199) == 0) run = 1'b0;
      else if (!run && $urandom_range(0, 9) == 0) run = 1'b1;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      step(1);
    end
    rand_cnt = 1'b0;
    run = 1'b0; ready = 1'b1;
    step(30);

    // Asynchronous reset mid-MEASURE with a pending result.
    ready = 1'b0; mode = 2'b00; osc_count = 16'h5555; run = 1'b1;
    step(24);
    chk("pre_rst_valid", res_if.res_valid, 1);
    chk("pre_rst_measure", cnt_en, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_en_inv", en_inv_osc, 0);
    chk("arst_en_nand", en_nand_osc, 0);
    chk("arst_osc_sel", osc_sel, 0);
    chk("arst_cnt_clr", cnt_clr, 0);
    chk("arst_cnt_en", cnt_en, 0);
    chk("arst_valid", res_if.res_valid, 0);
    chk("arst_data", res_if.res_data, 0);
    chk("arst_src", res_if.res_src, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_busy", busy, 0);
    step(2);
    ready = 1'b1; rst_n = 1'b1;
    step(1);
    chk("post_rst_inv", en_inv_osc, 1);
    step(40);
    run = 1'b0;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/osc_meas_scheduler.md
Name: osc_meas_scheduler

Overview:
- Sequences the two ring oscillators and the shared edge counter through timed measurement cycles: settle, then count window, then capture, then gap.
- In auto mode it alternates between the inverter and NAND oscillators.
- Each captured count goes into a one-entry result buffer with a valid/ready handshake to the averaging/UART send path.
- Sits between the pin-level control inputs and the oscillator enables, oscillator mux select and counter clear/enable.

Parameters:
- CNT_W, 16, width of counter value and result.
- SETTLE_CYC, 16, clk cycles the oscillator runs with the counter held clear before counting (>=1).
- WINDOW_CYC, 1000, clk cycles the counter is enabled (>=1).
- GAP_CYC, 8, clk cycles with all oscillators off between measurements (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = keep scheduling measurements
- mode  in  2  00/11 alternate inv/nand, 01 inv only, 10 nand only
- osc_count  in  CNT_W  current value of the oscillator edge counter
- en_inv_osc  out  1  enable for the inverter ring oscillator
- en_nand_osc  out  1  enable for the NAND ring oscillator
- osc_sel  out  1  oscillator mux select (0 inv, 1 nand)
- cnt_clr  out  1  synchronous clear to the counter
- cnt_en  out  1  counting enable
- res_data  out  CNT_W  captured count
- res_src  out  1  source of res_data (0 inv, 1 nand)
- res_valid  out  1  result buffer full
- res_ready  in  1  consumer accepts result when res_valid & res_ready
- overrun  out  1  one-cycle pulse when a capture is dropped
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; next source is inv.
  - Reset asserted mid-operation aborts immediately and discards any pending result.
- Control outputs are Moore outputs, decoded from the registered state and the registered current source. There is no combinational input-to-output path.
- IDLE:
  - All control outputs are 0.
  - If run=1, go to SETTLE on the next edge.
  - The source is chosen at SETTLE entry: mode 01 gives inv, mode 10 gives nand, alternate gives the toggled next-source register.
  - The source is latched for the whole measurement. Mode changes take effect only at the next SETTLE entry.
- SETTLE:
  - Lasts SETTLE_CYC cycles.
  - The selected enable is 1 and osc_sel = source.
  - cnt_clr=1, cnt_en=0.
- MEASURE:
  - Lasts WINDOW_CYC cycles.
  - The enable stays 1, cnt_clr=0, cnt_en=1.
- CAPTURE:
  - Lasts 1 cycle; the enable stays 1 and cnt_en=0.
  - osc_count is sampled at the end of this cycle.
  - In alternate mode the next-source register toggles.
- GAP:
  - Lasts GAP_CYC cycles; all enables, cnt_clr and cnt_en are 0.
  - At the end of GAP, go to SETTLE if run=1, otherwise to IDLE.
- Period per measurement = SETTLE_CYC + WINDOW_CYC + 1 + GAP_CYC cycles.
- en_inv_osc and en_nand_osc are never both 1.
- run=0 in SETTLE, MEASURE or CAPTURE:
  - Abort to IDLE on the next edge; the cycle with run=0 is completed in its current state.
  - No result is produced and the source does not toggle.
  - run=0 in GAP is handled at the end of GAP as above.
- Result buffer:
  - On capture, if res_valid=0 or (res_valid & res_ready): load res_data and res_src, and res_valid=1 on the following cycle.
  - Otherwise keep the old result and pulse overrun for 1 cycle.
  - res_valid clears on a res_valid & res_ready handshake with no capture in the same cycle.
  - res_data and res_src are stable while res_valid=1.
  - A pending result survives run=0 and the return to IDLE.
- Timer:
  - One down-counter, width $clog2 of max(SETTLE_CYC, WINDOW_CYC, GAP_CYC).
  - Loaded with N-1 on state entry; the state exits when the timer reaches 0.

Decomposition:
- Package osc_sched_pkg holds:
  - state encoding (IDLE, SETTLE, MEASURE, CAPTURE, GAP);
  - MODE_ALT, MODE_INV, MODE_NAND constants;
  - SRC_INV/SRC_NAND constants.
- Sub-module sched_timer: a loadable down-counter with a zero flag, with inputs load, load_val and dec.

Test Plan (SETTLE_CYC=4, WINDOW_CYC=10, GAP_CYC=2, CNT_W=16):
- Reset, mode=00, run=1 at t0, res_ready=1 → SETTLE entered t0+1:
  - en_inv_osc=1 t0+1..t0+15;
  - cnt_clr=1 t0+1..t0+4;
  - cnt_en=1 t0+5..t0+14;
  - osc_count=0x1234 at t0+15 gives res_valid=1, res_data=0x1234, res_src=0 at t0+16;
  - next SETTLE at t0+18 with en_nand_osc=1, osc_sel=1.
- mode=10, run held 1 for 3 measurements → three results, all res_src=1; en_inv_osc never 1; period 17 cycles.
- res_ready=0 across two captures (0x0100, then 0x0200) → res_data stays 0x0100, one overrun pulse at the second capture. Raising res_ready then gives one handshake and res_valid=0.
- Capture cycle coincides with a res_valid & res_ready handshake → new data loaded, res_valid stays 1, overrun=0.
- run=0 at the 3rd MEASURE cycle → IDLE next cycle, all enables and cnt_en 0, no result, source not toggled: the next run in mode 00 measures the same source again.
- rst_n low mid-MEASURE with a pending result → all outputs 0 immediately (asynchronous), res_valid=0. After release with run=1, the first measurement uses inv.
